// File: rtl/regfile_write_buffer.sv
// Write buffer in front of the register file: two producers (memory load has priority over ALU)
// feed a small FIFO that drains one entry per cycle, with newest-match bypass for both read ports.
module regfile_write_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_reg,
    input  logic [WIDTH-1:0]         alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_reg,
    input  logic [WIDTH-1:0]         mem_data,
    output logic                     mem_ready,
    input  logic                     drain_en,
    output logic                     write,
    output logic [AW-1:0]            wreg,
    output logic [WIDTH-1:0]         wd,
    input  logic [AW-1:0]            rreg1,
    input  logic [AW-1:0]            rreg2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [WIDTH-1:0]         fwd1_data,
    output logic [WIDTH-1:0]         fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    reg_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;

    logic             enq, deq, enq_ok;
    logic [AW-1:0]    enq_reg;
    logic [WIDTH-1:0] enq_data;
    logic [PW-1:0]    head_ptr;
    logic [DEPTH-1:0] slot_valid;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

    assign deq       = drain_en && !empty;
    assign enq_ok    = !full || deq;
    assign mem_ready = enq_ok;
    assign alu_ready = enq_ok && !mem_valid;
    assign enq       = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign enq_reg   = mem_valid ? mem_reg  : alu_reg;
    assign enq_data  = mem_valid ? mem_data : alu_data;

    // When idle the port keeps showing the entry that drained last.
    assign head_ptr  = empty ? (rd_ptr_q - 1'b1) : rd_ptr_q;
    assign write     = deq;
    assign wreg      = reg_q[head_ptr];
    assign wd        = data_q[head_ptr];

    always_comb begin
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (enq && !deq)
            count_d = count_q + 1'b1;
        else if (deq && !enq)
            count_d = count_q - 1'b1;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [PW-1:0] age;
            assign age            = PW'(gi) - rd_ptr_q;
            assign slot_valid[gi] = ({1'b0, age} < count_q);
        end
    endgenerate

    // Scan oldest to newest so the newest matching entry overwrites earlier ones.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = rd_ptr_q + PW'(k);
            if (slot_valid[idx] && reg_q[idx] == rreg1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = data_q[idx];
            end
            if (slot_valid[idx] && reg_q[idx] == rreg2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                reg_q[wr_ptr_q]  <= enq_reg;
                data_q[wr_ptr_q] <= enq_data;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Randomised and directed bench; a queue model predicts handshakes, occupancy and bypass,
// and a separate monitor checks every register file write against a scoreboard.
module tb_regfile_write_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, drain_en;
    logic [2:0]  alu_reg, mem_reg, rreg1, rreg2;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, write;
    logic [2:0]  wreg;
    logic [15:0] wd;
    logic        fwd1_hit, fwd2_hit;
    logic [15:0] fwd1_data, fwd2_data;
    logic [2:0]  count;
    logic        full, empty;

    int total = 0;
    int bad   = 0;

    ent_t mdl_q[$];
    ent_t exp_q[$];

    regfile_write_buffer dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .drain_en(drain_en), .write(write), .wreg(wreg), .wd(wd),
        .rreg1(rreg1), .rreg2(rreg2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding accepted result.
    always @(negedge clk) begin
        #2;
        if (rst && write === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got reg=%0d data=%h required none", wreg, wd);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                $display("write reg=%0d data=%h (expect reg=%0d data=%h)", wreg, wd, e.r, e.d);
                chk("wreg", 32'(wreg), 32'(e.r));
                chk("wd", 32'(wd), 32'(e.d));
            end
        end
    end

    function automatic void lookup(input logic [2:0] r, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (mdl_q[i]) begin
            if (mdl_q[i].r == r) begin
                hit = 1'b1;
                d   = mdl_q[i].d;
            end
        end
    endfunction

    task automatic cycle(input logic mv, input logic [2:0] mr, input logic [15:0] md,
                         input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic de, input logic [2:0] r1, input logic [2:0] r2);
        int          n;
        logic        deq_e, allow, h1, h2;
        logic [15:0] d1, d2;
        ent_t        e;
        @(negedge clk);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        drain_en  = de; rreg1 = r1; rreg2 = r2;
        #1;
        n     = mdl_q.size();
        deq_e = de && (n > 0);
        allow = (n < DEPTH) || deq_e;
        lookup(r1, h1, d1);
        lookup(r2, h2, d2);
        chk("mem_ready", 32'(mem_ready), 32'(allow));
        chk("alu_ready", 32'(alu_ready), 32'(allow && !mv));
        chk("write", 32'(write), 32'(deq_e));
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("fwd1_hit", 32'(fwd1_hit), 32'(h1));
        chk("fwd1_data", 32'(fwd1_data), 32'(d1));
        chk("fwd2_hit", 32'(fwd2_hit), 32'(h2));
        chk("fwd2_data", 32'(fwd2_data), 32'(d2));
        if (deq_e) void'(mdl_q.pop_front());
        if (allow && (mv || av)) begin
            e.r = mv ? mr : ar;
            e.d = mv ? md : ad;
            mdl_q.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic de);
        cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, de, 3'd0, 3'd0);
    endtask

    initial begin
        rst = 1'b0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        drain_en = 1'b0; rreg1 = '0; rreg2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_wreg", 32'(wreg), 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_fwd1", 32'(fwd1_hit), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic flow
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Memory priority, ALU retried next cycle
        cycle(1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd2, 16'h0001, 1'b0, 3'd5, 3'd2);
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h0001, 1'b0, 3'd5, 3'd2);
        repeat (3) idle(1'b1);

        // Fill, back-pressure, then sustained enqueue+dequeue while full
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'(i + 4), 16'(16'hA0 + i), 1'b0, 3'd4, 3'd7);
        cycle(1'b1, 3'd1, 16'hDEAD, 1'b1, 3'd1, 16'hDEAD, 1'b0, 3'd1, 3'd4);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 16'(16'hC0 + i), 1'b1, 3'(i), 3'd5);
        repeat (5) idle(1'b1);

        // Newest entry wins the bypass
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h0011, 1'b0, 3'd1, 3'd4);
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h0022, 1'b0, 3'd1, 3'd4);
        cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd4);
        chk("fwd_newest", 32'(fwd1_data), 32'h0022);
        repeat (3) cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd4);

        // Wrap-around with continuous drain
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 16'(i), 1'b1, 3'(i), 3'd0);
        repeat (2) idle(1'b1);

        // Reset with two queued writes while a write is being presented
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h6666, 1'b0, 3'd6, 3'd0);
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd6, 3'd0);
        @(negedge clk);
        alu_valid = 1'b0; drain_en = 1'b1; rreg1 = 3'd6;
        #1;
        chk("pre_rst_write", 32'(write), 32'd1);
        rst = 1'b0;
        #0.5;
        chk("mid_rst_write", 32'(write), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_fwd1", 32'(fwd1_hit), 32'd0);
        @(negedge clk);
        drain_en = 1'b0;
        rst = 1'b1;
        mdl_q.delete();
        exp_q.delete();
        repeat (3) idle(1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  1'($urandom_range(0, 4) < 3), 3'($urandom), 3'($urandom));
        repeat (DEPTH + 2) idle(1'b1);
        @(negedge clk);
        #3;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
